// File: rtl/conv_result_mem.sv
// Convolution result memory: NUM_CH interleaved banks with per-entry valid bits.
// Writes come from the core (auto-increment) or the host (explicit); one read returns a whole row.

module conv_result_bank #(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 5,
  parameter int ROW_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  we,
  input  logic [ROW_WIDTH-1:0]  wrow,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ROW_WIDTH-1:0]  rrow,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvld,
  output logic                  wvld
);
  logic [DATA_WIDTH-1:0] mem [ROWS];
  logic [ROWS-1:0]       vbits;

  // Array contents are deliberately left out of reset.
  always_ff @(posedge clk)
    if (we) mem[wrow] <= wdata;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)     vbits <= '0;
    else if (clear) vbits <= '0;
    else if (we)    vbits[wrow] <= 1'b1;

  assign rdata = mem[rrow];
  assign rvld  = vbits[rrow];
  assign wvld  = vbits[wrow];
endmodule

module conv_result_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH     = 2,
  parameter int DEPTH      = 10,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int ROW_WIDTH  = ((DEPTH / NUM_CH) > 1) ? $clog2(DEPTH / NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         wr_en,
  input  logic                         wr_auto,
  input  logic [ADDR_WIDTH-1:0]        wr_addr,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic                         rd_en,
  input  logic [ROW_WIDTH-1:0]         rd_row,
  output logic [NUM_CH*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_CH-1:0]            rd_vmask,
  output logic                         rd_valid,
  output logic [ADDR_WIDTH:0]          count,
  output logic                         full,
  output logic                         done,
  output logic                         wr_err
);
  localparam int ROWS = DEPTH / NUM_CH;
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [ADDR_WIDTH:0]   FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_A   = ADDR_WIDTH'(DEPTH - 1);

  logic [ADDR_WIDTH-1:0] ptr, a;
  logic [CH_W-1:0]       wbank;
  logic [ROW_WIDTH-1:0]  wrow;
  logic                  a_bad, wr_rej, accept, inc, rd_in;
  logic [NUM_CH-1:0]     bwe, bwvld, brvld;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0] brdata;

  // NUM_CH is a power of two, so mod/div reduce to bit select and shift.
  assign a      = wr_auto ? ptr : wr_addr;
  assign wbank  = CH_W'(a % NUM_CH);
  assign wrow   = ROW_WIDTH'(a / NUM_CH);
  assign a_bad  = int'(a) >= DEPTH;
  assign wr_rej = wr_en && !clear && (a_bad || (wr_auto && full));
  assign accept = wr_en && !clear && !a_bad && !(wr_auto && full);
  assign inc    = accept && !bwvld[wbank];
  assign rd_in  = int'(rd_row) < ROWS;
  assign full   = (count == FULL_CNT);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_bank
    assign bwe[c] = accept && (wbank == CH_W'(c));
    conv_result_bank #(
      .DATA_WIDTH(DATA_WIDTH), .ROWS(ROWS), .ROW_WIDTH(ROW_WIDTH)
    ) u_bank (
      .clk(clk), .rst_n(rst_n), .clear(clear), .we(bwe[c]),
      .wrow(wrow), .wdata(wr_data), .rrow(rd_row),
      .rdata(brdata[c]), .rvld(brvld[c]), .wvld(bwvld[c])
    );
  end

  // Read port samples the banks before this edge's write lands: read-before-write.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_vmask <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data  <= rd_in ? brdata : '0;
        rd_vmask <= rd_in ? brvld  : '0;
      end
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ptr    <= '0;
      count  <= '0;
      done   <= 1'b0;
      wr_err <= 1'b0;
    end else if (clear) begin
      ptr    <= '0;
      count  <= '0;
      done   <= 1'b0;
      wr_err <= 1'b0;
    end else begin
      done <= inc && (count == FULL_CNT - 1'b1);
      if (inc)                count  <= count + 1'b1;
      if (wr_rej)             wr_err <= 1'b1;
      if (accept && wr_auto)  ptr    <= (ptr == LAST_A) ? '0 : ptr + 1'b1;
    end
endmodule
